// File: rtl/ldst_bus_pkg.sv
// Shared definitions for the LD/ST peripheral bus arbiter.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package ldst_bus_pkg;

    // Arbiter FSM encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEQ_XFER  = 3'd1;
    localparam logic [2:0] ST_HOST_XFER = 3'd2;
    localparam logic [2:0] ST_SEQ_DONE  = 3'd3;
    localparam logic [2:0] ST_HOST_DONE = 3'd4;

    // Sequencer addresses at or below this value are core-internal and never reach the bus
    localparam logic [7:0] INTERNAL_ADDR_LIMIT = 8'h03;

    // Peripheral wait cycles before a transfer is forced to complete
    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

    // Completion data returned when a peripheral never answers
    localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

    // Round-robin owner of the most recent grant
    localparam logic GRANT_SEQ  = 1'b0;
    localparam logic GRANT_HOST = 1'b1;

    // True when a sequencer address targets the shared peripheral bus
    function automatic logic is_periph_addr(input logic [7:0] addr);
        return addr > INTERNAL_ADDR_LIMIT;
    endfunction

endpackage

// File: rtl/ldst_bus_watchdog.sv
// Counts cycles spent waiting on a peripheral and flags the final permitted cycle.
// Latency: expired is combinational in the TIMEOUT_CYCLES-th run cycle after start.
// Backpressure: none; counter simply holds when run is low.
module ldst_bus_watchdog
    import ldst_bus_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic run,
    output logic expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Clear on transfer entry, advance once per waiting cycle
    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = 8'd0;
        end else if (run) begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // The current run cycle is the last one allowed (count_q cycles already elapsed)
    assign expired = run && (({1'b0, count_q} + 9'd1) >= {1'b0, TIMEOUT_CYCLES});

endmodule

// File: rtl/ldst_bus_arbiter.sv
// Arbitrates the LD/ST sequencer and a host onto one peripheral bus, stalling the sequencer's step enable.
// Latency: request in IDLE cycle N, ready in N+1 -> completion (ack / sequencer DONE) in N+2.
// Backpressure: peripheral via periph_ready (watchdog-bounded); sequencer DONE waits for enable.
module ldst_bus_arbiter
    import ldst_bus_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    output logic       seq_clock_enable,
    input  logic [7:0] seq_io_address,
    input  logic [7:0] seq_io_data_out,
    input  logic       seq_io_out,
    input  logic       seq_io_in,
    output logic [7:0] seq_io_data_in,
    input  logic [7:0] host_address,
    input  logic [7:0] host_data_out,
    input  logic       host_write,
    input  logic       host_read,
    output logic [7:0] host_data_in,
    output logic       host_ack,
    output logic [7:0] periph_address,
    output logic [7:0] periph_data_out,
    output logic       periph_write,
    output logic       periph_read,
    input  logic [7:0] periph_data_in,
    input  logic       periph_ready,
    output logic       timeout_error,
    input  logic       error_clear
);

    logic [2:0] state_q,      state_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] addr_q,       addr_d;
    logic [7:0] wdat_q,       wdat_d;
    logic       wr_q,         wr_d;
    logic [7:0] data_q,       data_d;
    logic       err_q,        err_d;

    logic seq_req;
    logic host_req;
    logic in_xfer;
    logic wd_start;
    logic wd_expired;
    logic timeout_hit;

    assign seq_req  = (seq_io_in || seq_io_out) && is_periph_addr(seq_io_address);
    assign host_req = host_read || host_write;
    assign in_xfer  = (state_q == ST_SEQ_XFER) || (state_q == ST_HOST_XFER);

    ldst_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (wd_start),
        .run     (in_xfer),
        .expired (wd_expired)
    );

    // Grant, transfer completion and error bookkeeping
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdat_d       = wdat_q;
        wr_d         = wr_q;
        data_d       = data_q;
        wd_start     = 1'b0;
        timeout_hit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Under contention the port that did not win last time is served
                if (seq_req && (!host_req || last_grant_q == GRANT_HOST)) begin
                    state_d      = ST_SEQ_XFER;
                    last_grant_d = GRANT_SEQ;
                    addr_d       = seq_io_address;
                    wdat_d       = seq_io_data_out;
                    wr_d         = seq_io_out;
                    wd_start     = 1'b1;
                end else if (host_req) begin
                    state_d      = ST_HOST_XFER;
                    last_grant_d = GRANT_HOST;
                    addr_d       = host_address;
                    wdat_d       = host_data_out;
                    wr_d         = host_write;
                    wd_start     = 1'b1;
                end
            end
            ST_SEQ_XFER, ST_HOST_XFER: begin
                // A late ready still wins over the timeout in the same cycle
                if (periph_ready || wd_expired) begin
                    state_d = (state_q == ST_SEQ_XFER) ? ST_SEQ_DONE : ST_HOST_DONE;
                    if (periph_ready) begin
                        data_d = wr_q ? 8'h00 : periph_data_in;
                    end else begin
                        data_d      = TIMEOUT_DATA;
                        timeout_hit = 1'b1;
                    end
                end
            end
            ST_SEQ_DONE: begin
                if (enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new timeout beats a simultaneous clear
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (error_clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State and latch registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_HOST;
            addr_q       <= 8'h00;
            wdat_q       <= 8'h00;
            wr_q         <= 1'b0;
            data_q       <= 8'h00;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdat_q       <= wdat_d;
            wr_q         <= wr_d;
            data_q       <= data_d;
            err_q        <= err_d;
        end
    end

    // Bus is driven purely from the grant-time latches; strobes only while transferring
    assign periph_address  = addr_q;
    assign periph_data_out = wdat_q;
    assign periph_write    = in_xfer && wr_q;
    assign periph_read     = in_xfer && !wr_q;

    // Sequencer steps freely unless it is waiting on the bus; held low during reset
    assign seq_clock_enable = reset_n && enable &&
                              (((state_q == ST_IDLE) && !seq_req) || (state_q == ST_SEQ_DONE));

    assign seq_io_data_in = (state_q == ST_SEQ_DONE)  ? data_q : 8'h00;
    assign host_data_in   = (state_q == ST_HOST_DONE) ? data_q : 8'h00;
    assign host_ack       = (state_q == ST_HOST_DONE);
    assign timeout_error  = err_q;

endmodule

// File: tb/tb_ldst_bus_arbiter.sv
// Directed self-checking bench: transaction-phase model checked every cycle plus literal scenario checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_ldst_bus_arbiter;

    localparam int TB_TIMEOUT = 255;
    localparam int PH_IDLE    = 0;
    localparam int PH_BUSY    = 1;
    localparam int PH_DONE    = 2;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       seq_clock_enable;
    logic [7:0] seq_io_address;
    logic [7:0] seq_io_data_out;
    logic       seq_io_out;
    logic       seq_io_in;
    logic [7:0] seq_io_data_in;
    logic [7:0] host_address;
    logic [7:0] host_data_out;
    logic       host_write;
    logic       host_read;
    logic [7:0] host_data_in;
    logic       host_ack;
    logic [7:0] periph_address;
    logic [7:0] periph_data_out;
    logic       periph_write;
    logic       periph_read;
    logic [7:0] periph_data_in;
    logic       periph_ready;
    logic       timeout_error;
    logic       error_clear;

    int n_cmp = 0;
    int n_bad = 0;

    ldst_bus_arbiter #(
        .TIMEOUT_CYCLES (8'd255)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .enable           (enable),
        .seq_clock_enable (seq_clock_enable),
        .seq_io_address   (seq_io_address),
        .seq_io_data_out  (seq_io_data_out),
        .seq_io_out       (seq_io_out),
        .seq_io_in        (seq_io_in),
        .seq_io_data_in   (seq_io_data_in),
        .host_address     (host_address),
        .host_data_out    (host_data_out),
        .host_write       (host_write),
        .host_read        (host_read),
        .host_data_in     (host_data_in),
        .host_ack         (host_ack),
        .periph_address   (periph_address),
        .periph_data_out  (periph_data_out),
        .periph_write     (periph_write),
        .periph_read      (periph_read),
        .periph_data_in   (periph_data_in),
        .periph_ready     (periph_ready),
        .timeout_error    (timeout_error),
        .error_clear      (error_clear)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: one transaction at a time ----------------
    bit         m_valid     = 0;
    int         m_phase     = PH_IDLE;
    bit         m_who_host  = 0;
    bit         m_last_host = 1;
    bit         m_wr        = 0;
    logic [7:0] m_addr      = 8'h00;
    logic [7:0] m_wdat      = 8'h00;
    logic [7:0] m_data      = 8'h00;
    int         m_elapsed   = 0;
    bit         m_err       = 0;
    bit         u_sreq, u_hreq, u_tmo;

    always @(posedge clock) begin
        u_sreq = (seq_io_in || seq_io_out) && (seq_io_address >= 8'h04);
        u_hreq = host_read || host_write;
        u_tmo  = 0;
        if (!reset_n) begin
            m_valid = 1; m_phase = PH_IDLE; m_last_host = 1; m_err = 0;
            m_addr = 8'h00; m_wdat = 8'h00; m_data = 8'h00; m_wr = 0; m_elapsed = 0;
        end else begin
            case (m_phase)
                PH_IDLE: if (u_sreq || u_hreq) begin
                    m_who_host  = u_hreq && (!u_sreq || !m_last_host);
                    m_last_host = m_who_host;
                    m_addr      = m_who_host ? host_address  : seq_io_address;
                    m_wdat      = m_who_host ? host_data_out : seq_io_data_out;
                    m_wr        = m_who_host ? host_write    : seq_io_out;
                    m_elapsed   = 0;
                    m_phase     = PH_BUSY;
                end
                PH_BUSY: begin
                    m_elapsed++;
                    if (periph_ready) begin
                        m_data  = m_wr ? 8'h00 : periph_data_in;
                        m_phase = PH_DONE;
                    end else if (m_elapsed >= TB_TIMEOUT) begin
                        m_data  = 8'hFF;
                        u_tmo   = 1;
                        m_phase = PH_DONE;
                    end
                end
                default: if (m_who_host || enable) m_phase = PH_IDLE;
            endcase
            if (u_tmo) m_err = 1;
            else if (error_clear) m_err = 0;
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    bit c_sreq, c_busy, c_sdone, c_hdone;

    always @(negedge clock) begin
        if (m_valid) begin
            c_sreq  = (seq_io_in || seq_io_out) && (seq_io_address >= 8'h04);
            c_busy  = (m_phase == PH_BUSY);
            c_sdone = (m_phase == PH_DONE) && !m_who_host;
            c_hdone = (m_phase == PH_DONE) && m_who_host;
            check("mdl.seq_clock_enable", 32'(seq_clock_enable),
                  32'(reset_n && enable && ((m_phase == PH_IDLE && !c_sreq) || c_sdone)));
            check("mdl.periph_read",  32'(periph_read),  32'(c_busy && !m_wr));
            check("mdl.periph_write", 32'(periph_write), 32'(c_busy && m_wr));
            if (c_busy) begin
                check("mdl.periph_address",  32'(periph_address),  32'(m_addr));
                check("mdl.periph_data_out", 32'(periph_data_out), 32'(m_wdat));
            end
            check("mdl.seq_io_data_in", 32'(seq_io_data_in), 32'(c_sdone ? m_data : 8'h00));
            check("mdl.host_ack",       32'(host_ack),       32'(c_hdone));
            check("mdl.host_data_in",   32'(host_data_in),   32'(c_hdone ? m_data : 8'h00));
            check("mdl.timeout_error",  32'(timeout_error),  32'(m_err));
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    int lows, pulses, pulse_i, xfer, acks, wr_at, rd_at, rd_seen;
    logic [7:0] pdat, dat2, ackdat, wr_addr, wr_dat, rd_addr;
    bit got, errat;

    initial begin
        reset_n = 0; enable = 1; error_clear = 0;
        seq_io_address = 0; seq_io_data_out = 0; seq_io_out = 0; seq_io_in = 0;
        host_address = 0; host_data_out = 0; host_write = 0; host_read = 0;
        periph_data_in = 0; periph_ready = 0;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst.seq_clock_enable", 32'(seq_clock_enable), 32'd0);
        check("rst.timeout_error", 32'(timeout_error), 32'd0);
        step();
        reset_n = 1;
        @(negedge clock);
        check("post_rst.seq_clock_enable", 32'(seq_clock_enable), 32'd1);
        check("post_rst.host_ack", 32'(host_ack), 32'd0);
        check("post_rst.periph_read", 32'(periph_read), 32'd0);
        step();

        // A: seq read 0x40, ready on third XFER cycle with 0x5A
        lows = 0; pulses = 0; pdat = 8'h00;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin seq_io_address = 8'h40; seq_io_in = 1; end
                3: begin periph_ready = 1; periph_data_in = 8'h5A; end
                4: begin periph_ready = 0; periph_data_in = 8'h00; end
                5: begin seq_io_in = 0; seq_io_address = 8'h00; end
                default: ;
            endcase
            @(negedge clock);
            if (i < 5) begin
                if (!seq_clock_enable) lows++;
                else begin pulses++; pdat = seq_io_data_in; end
            end
            step();
        end
        check("A.low_cycles", lows, 32'd4);
        check("A.pulses", pulses, 32'd1);
        check("A.pulse_data", 32'(pdat), 32'h5A);

        // B: contention after reset (last grant = host) -> seq write first, then host read
        reset_n = 0;
        step();
        reset_n = 1;
        wr_at = -1; rd_at = -1; acks = 0; ackdat = 8'h00;
        wr_addr = 8'h00; wr_dat = 8'h00; rd_addr = 8'h00;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin
                    seq_io_address = 8'h41; seq_io_data_out = 8'hC3; seq_io_out = 1;
                    host_address = 8'h80; host_read = 1;
                    periph_ready = 1; periph_data_in = 8'h77;
                end
                3: begin seq_io_out = 0; seq_io_address = 8'h00; seq_io_data_out = 8'h00; end
                6: begin host_read = 0; host_address = 8'h00; end
                8: begin periph_ready = 0; periph_data_in = 8'h00; end
                default: ;
            endcase
            @(negedge clock);
            if (periph_write && wr_at < 0) begin wr_at = i; wr_addr = periph_address; wr_dat = periph_data_out; end
            if (periph_read && rd_at < 0) begin rd_at = i; rd_addr = periph_address; end
            if (host_ack) begin acks++; ackdat = host_data_in; end
            step();
        end
        check("B.seq_write_cycle", wr_at, 32'd1);
        check("B.seq_write_addr", 32'(wr_addr), 32'h41);
        check("B.seq_write_data", 32'(wr_dat), 32'hC3);
        check("B.host_read_cycle", rd_at, 32'd4);
        check("B.host_read_addr", 32'(rd_addr), 32'h80);
        check("B.host_acks", acks, 32'd1);
        check("B.host_ack_data", 32'(ackdat), 32'h77);

        // C: internal address bypasses the bus; enable passes straight through
        rd_seen = 0;
        for (int i = 0; i < 5; i++) begin
            seq_io_address = 8'h02; seq_io_in = 1;
            enable = (i != 1 && i != 3);
            @(negedge clock);
            check("C.sce_follows_enable", 32'(seq_clock_enable), 32'(enable));
            if (periph_read) rd_seen++;
            step();
        end
        seq_io_in = 0; seq_io_address = 8'h00; enable = 1;
        check("C.no_periph_read", rd_seen, 32'd0);

        // D: host read with no ready -> timeout after 255 XFER cycles
        host_address = 8'h90; host_read = 1;
        got = 0; xfer = 0; ackdat = 8'h00; errat = 0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clock);
            if (periph_read) xfer++;
            if (host_ack) begin got = 1; ackdat = host_data_in; errat = timeout_error; end
            step();
            if (got) begin host_read = 0; host_address = 8'h00; end
        end
        check("D.ack_seen", 32'(got), 32'd1);
        check("D.xfer_cycles", xfer, 32'd255);
        check("D.ack_data", 32'(ackdat), 32'hFF);
        check("D.err_at_ack", 32'(errat), 32'd1);
        @(negedge clock);
        check("D.err_sticky", 32'(timeout_error), 32'd1);
        step();
        error_clear = 1;
        step();
        error_clear = 0;
        @(negedge clock);
        check("D.err_cleared", 32'(timeout_error), 32'd0);
        step();

        // E: SEQ_DONE held with enable low for 5 cycles, single pulse when enable returns
        pulses = 0; pulse_i = -1; dat2 = 8'h00;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: begin seq_io_address = 8'h50; seq_io_in = 1; periph_ready = 1; periph_data_in = 8'h3C; end
                2: begin periph_ready = 0; periph_data_in = 8'h00; enable = 0; end
                7: enable = 1;
                8: begin seq_io_in = 0; seq_io_address = 8'h00; end
                default: ;
            endcase
            @(negedge clock);
            if (i < 8 && seq_clock_enable) begin pulses++; pulse_i = i; end
            if (i == 2) dat2 = seq_io_data_in;
            step();
        end
        check("E.pulses", pulses, 32'd1);
        check("E.pulse_cycle", pulse_i, 32'd7);
        check("E.done_data", 32'(dat2), 32'h3C);

        // F: reset during HOST_XFER aborts without ack
        host_address = 8'hA0; host_read = 1; periph_ready = 0;
        step();
        @(negedge clock);
        check("F.read_in_xfer", 32'(periph_read), 32'd1);
        step();
        reset_n = 0;
        @(negedge clock);
        check("F.sce_in_reset", 32'(seq_clock_enable), 32'd0);
        step();
        reset_n = 1; host_read = 0; host_address = 8'h00;
        acks = 0;
        @(negedge clock);
        check("F.read_after_reset", 32'(periph_read), 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (host_ack) acks++;
            step();
            @(negedge clock);
        end
        check("F.no_ack", acks, 32'd0);
        step();

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
